mem_port_arbiter: RTL

Shares one single-port memory between the core's instruction-fetch port (i_m_*) and data port (d_m_*). The core sees two independent hit-based ports, and the memory sees one request stream. The block sits between the core top level and the unified memory. A registered FSM serialises accesses. Data has priority, with a starvation bound that guarantees fetch progress.

---
 rtl/mem_port_arbiter_if.sv | 43 ++++
 rtl/mem_port_arbiter.sv | 118 +++++++++++
 2 files changed

// File: rtl/mem_port_arbiter_if.sv
// Every core-side and memory-side signal of mem_port_arbiter, named as the block's ports.
// Request/hit protocol: a requester holds rden/wren high with stable addr/wdata/wmask until its
// one-cycle hit pulse. The hit is valid with rdata. There is no ready signal, so an ungranted
// request simply stays asserted.
interface mem_port_arbiter_if #(
  parameter int DataWidth = 32,
  parameter int AddrWidth = 32
);
  logic [AddrWidth-1:0]   i_m_addr_i;
  logic                   i_m_rden_i;
  logic [31:0]            i_m_rdata_o;
  logic                   i_m_hit_o;
  logic [AddrWidth-1:0]   d_m_addr_i;
  logic                   d_m_rden_i;
  logic                   d_m_wren_i;
  logic [DataWidth-1:0]   d_m_wdata_i;
  logic [DataWidth/8-1:0] d_m_wmask_i;
  logic [DataWidth-1:0]   d_m_rdata_o;
  logic                   d_m_hit_o;
  logic [AddrWidth-1:0]   m_addr_o;
  logic                   m_rden_o;
  logic                   m_wren_o;
  logic [DataWidth-1:0]   m_wdata_o;
  logic [DataWidth/8-1:0] m_wmask_o;
  logic [DataWidth-1:0]   m_rdata_i;
  logic                   m_hit_i;

  // Environment side: the core ports and the memory response.
  modport master (
    output i_m_addr_i, i_m_rden_i, d_m_addr_i, d_m_rden_i, d_m_wren_i, d_m_wdata_i, d_m_wmask_i,
           m_rdata_i, m_hit_i,
    input  i_m_rdata_o, i_m_hit_o, d_m_rdata_o, d_m_hit_o, m_addr_o, m_rden_o, m_wren_o,
           m_wdata_o, m_wmask_o
  );

  // Arbiter side.
  modport slave (
    input  i_m_addr_i, i_m_rden_i, d_m_addr_i, d_m_rden_i, d_m_wren_i, d_m_wdata_i, d_m_wmask_i,
           m_rdata_i, m_hit_i,
    output i_m_rdata_o, i_m_hit_o, d_m_rdata_o, d_m_hit_o, m_addr_o, m_rden_o, m_wren_o,
           m_wdata_o, m_wmask_o
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between the fetch and data ports. Data has priority, and fetch
// is guaranteed a grant after at most MaxDataBurst consecutive data grants.
module mem_port_arbiter #(
  parameter int DataWidth    = 32,
  parameter int AddrWidth    = 32,
  parameter int MaxDataBurst = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  mem_port_arbiter_if.slave bus,
  output logic [1:0]        dbg_state_o,     // 0 IDLE, 1 I_BUSY, 2 D_BUSY
  output logic [3:0]        dbg_burst_cnt_o
);
  localparam int MaskWidth = DataWidth / 8;

  if (DataWidth != 32 && DataWidth != 64) begin : g_bad_width
    $fatal(1, "mem_port_arbiter: DataWidth must be 32 or 64");
  end
  if (MaxDataBurst < 1 || MaxDataBurst > 15) begin : g_bad_burst
    $fatal(1, "mem_port_arbiter: MaxDataBurst must be 1..15");
  end

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    I_BUSY = 2'd1,
    D_BUSY = 2'd2
  } state_e;

  state_e                 state_q;
  logic [3:0]             burst_cnt_q;
  logic [AddrWidth-1:0]   addr_q;
  logic                   rden_q;
  logic                   wren_q;
  logic [DataWidth-1:0]   wdata_q;
  logic [MaskWidth-1:0]   wmask_q;
  logic                   d_req;
  logic                   burst_ok;
  logic                   d_win;

  assign d_req    = bus.d_m_rden_i | bus.d_m_wren_i;
  assign burst_ok = burst_cnt_q < 4'(MaxDataBurst);
  assign d_win    = d_req & (~bus.i_m_rden_i | burst_ok);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      burst_cnt_q <= '0;
      addr_q      <= '0;
      rden_q      <= 1'b0;
      wren_q      <= 1'b0;
      wdata_q     <= '0;
      wmask_q     <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (d_win) begin
            state_q     <= D_BUSY;
            addr_q      <= bus.d_m_addr_i;
            rden_q      <= bus.d_m_rden_i & ~bus.d_m_wren_i;
            wren_q      <= bus.d_m_wren_i;
            wdata_q     <= bus.d_m_wdata_i;
            wmask_q     <= bus.d_m_wmask_i;
            // d_win already implies burst_cnt_q < MaxDataBurst, so this saturates by construction.
            burst_cnt_q <= bus.i_m_rden_i ? burst_cnt_q + 4'd1 : 4'd0;
          end else if (bus.i_m_rden_i) begin
            state_q     <= I_BUSY;
            addr_q      <= bus.i_m_addr_i;
            rden_q      <= 1'b1;
            wren_q      <= 1'b0;
            wdata_q     <= '0;
            wmask_q     <= '0;
            burst_cnt_q <= '0;
          end else begin
            burst_cnt_q <= '0;
          end
        end
        I_BUSY, D_BUSY: begin
          if (bus.m_hit_i) begin
            state_q <= IDLE;
            rden_q  <= 1'b0;
            wren_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          rden_q  <= 1'b0;
          wren_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.m_addr_o  = addr_q;
  assign bus.m_rden_o  = rden_q;
  assign bus.m_wren_o  = wren_q;
  assign bus.m_wdata_o = wdata_q;
  assign bus.m_wmask_o = wmask_q;

  // A requester that dropped its request mid-transaction gets no hit.
  assign bus.i_m_hit_o   = (state_q == I_BUSY) & bus.m_hit_i & bus.i_m_rden_i;
  assign bus.d_m_hit_o   = (state_q == D_BUSY) & bus.m_hit_i & d_req;
  assign bus.d_m_rdata_o = bus.m_rdata_i;

  if (DataWidth == 64) begin : g_lane64
    assign bus.i_m_rdata_o = addr_q[2] ? bus.m_rdata_i[63:32] : bus.m_rdata_i[31:0];
  end else begin : g_lane32
    assign bus.i_m_rdata_o = bus.m_rdata_i;
  end

  assign dbg_state_o     = state_q;
  assign dbg_burst_cnt_o = burst_cnt_q;

  always_ff @(posedge clk_i) begin
    if (!rst_i && state_q == IDLE) begin
      assert (!bus.m_hit_i) else $error("mem_port_arbiter: m_hit_i while IDLE");
    end
  end
endmodule
